// File: rtl/func7_pkg.sv
// ----------------------------------------------------------------------------
// func7_pkg : shared types and constants for the 7-input function flow
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package func7_pkg;

    localparam int N_IN  = 7;
    localparam int TT_W  = 128;
    localparam int CNT_W = 8;

    typedef logic [TT_W-1:0] tt_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } tt_scan_state_t;

    // Byte-wise counts first, then a sum of the sixteen partial counts.
    // The total never exceeds 128, so 8 bits cannot wrap.
    function automatic logic [CNT_W-1:0] tt_popcount(input tt_t v);
        logic [3:0]       byte_cnt;
        logic [CNT_W-1:0] acc;
        acc = '0;
        for (int b = 0; b < TT_W / 8; b++) begin
            byte_cnt = '0;
            for (int k = 0; k < 8; k++) begin
                byte_cnt = byte_cnt + 4'(v[b*8+k]);
            end
            acc = acc + CNT_W'(byte_cnt);
        end
        return acc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tt_lat_pipe.sv
// ----------------------------------------------------------------------------
// tt_lat_pipe : LAT-deep (valid, index) delay line; a plain wire at LAT = 0
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tt_lat_pipe #(
    parameter int LAT   = 0,
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    input  logic [IDX_W-1:0] i_idx,
    output logic             o_vld,
    output logic [IDX_W-1:0] o_idx
);

    generate
        if (LAT == 0) begin : g_wire
            logic w_unused;
            assign w_unused = clk ^ rst;
            assign o_vld    = i_vld;
            assign o_idx    = i_idx;
        end else begin : g_shift
            logic [LAT-1:0]   r_vld;
            logic [IDX_W-1:0] r_idx [LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld <= '0;
                    for (int k = 0; k < LAT; k++) begin
                        r_idx[k] <= '0;
                    end
                end else begin
                    r_vld[0] <= i_vld;
                    r_idx[0] <= i_idx;
                    for (int k = 1; k < LAT; k++) begin
                        r_vld[k] <= r_vld[k-1];
                        r_idx[k] <= r_idx[k-1];
                    end
                end
            end

            assign o_vld = r_vld[LAT-1];
            assign o_idx = r_idx[LAT-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/tt_scanner.sv
// ----------------------------------------------------------------------------
// tt_scanner : sweeps all 128 minterms, rebuilds the truth table, compares it
//              against an expected table and reports its popcount.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tt_scanner
    import func7_pkg::*;
#(
    parameter int LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  tt_t              exp_tt,
    output logic [N_IN-1:0]  x,
    input  logic             f_in,
    output logic             busy,
    output logic             tt_valid,
    input  logic             tt_ready,
    output tt_t              tt_data,
    output logic             match,
    output logic [CNT_W-1:0] ones
);

    localparam logic [N_IN-1:0] C_LAST_X = '1;

    tt_scan_state_t   r_state;
    logic [N_IN-1:0]  r_x;
    tt_t              r_tt;
    tt_t              r_exp;
    logic             r_busy;
    logic             r_valid;
    logic             r_match;
    logic [CNT_W-1:0] r_ones;

    logic             w_drv_vld;
    logic             w_smp_vld;
    logic [N_IN-1:0]  w_smp_idx;
    logic             w_last;
    tt_t              w_tt_next;
    logic             w_match;
    logic [CNT_W-1:0] w_ones;

    // Each driven minterm is tagged so its response lands in the right bit
    // regardless of the function-under-test latency.
    assign w_drv_vld = (r_state == ST_SCAN);

    tt_lat_pipe #(
        .LAT   (LAT),
        .IDX_W (N_IN)
    ) u_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_vld (w_drv_vld),
        .i_idx (r_x),
        .o_vld (w_smp_vld),
        .o_idx (w_smp_idx)
    );

    assign w_last = w_smp_vld && (w_smp_idx == C_LAST_X);

    always_comb begin
        w_tt_next = r_tt;
        if (w_smp_vld) begin
            w_tt_next[w_smp_idx] = f_in;
        end
    end

    // Compare and count use the table including the sample written on the
    // same edge, so both are ready in the first valid cycle.
    assign w_match = (w_tt_next == r_exp);
    assign w_ones  = tt_popcount(w_tt_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_x     <= '0;
            r_tt    <= '0;
            r_exp   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_match <= 1'b0;
            r_ones  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SCAN;
                        r_x     <= '0;
                        r_tt    <= '0;
                        r_exp   <= exp_tt;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    r_tt <= w_tt_next;
                    if (r_x == C_LAST_X) begin
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_valid <= 1'b1;
                            r_match <= w_match;
                            r_ones  <= w_ones;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    r_tt <= w_tt_next;
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                        r_match <= w_match;
                        r_ones  <= w_ones;
                    end
                end
                ST_DONE: begin
                    if (tt_ready) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign x        = r_x;
    assign busy     = r_busy;
    assign tt_valid = r_valid;
    assign tt_data  = r_tt;
    assign match    = r_match;
    assign ones     = r_ones;

endmodule

`default_nettype wire

// File: tb/tb_tt_scanner.sv
// ----------------------------------------------------------------------------
// tb_tt_scanner : scoreboard bench for tt_scanner at LAT = 0 and LAT = 3
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_tt_scanner;
    import func7_pkg::*;

    typedef struct packed {
        tt_t        tt;
        logic       m;
        logic [7:0] n;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start;
    logic [1:0] ready;
    tt_t        exp_a [2];
    logic [6:0] xv    [2];
    logic [1:0] busy;
    logic [1:0] valid;
    logic [1:0] match;
    tt_t        data  [2];
    logic [7:0] ones  [2];
    logic       f_in0;
    logic       f_in3;
    logic [2:0] dly = 3'b000;
    int         fsel;

    tt_t c_tt5  = 128'hfee8eaa8eaa8e8a8eae8eaa8eaa8e880;
    tt_t c_maj3 = {16{8'hE8}};

    exp_t sb [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic fval(input int fs, input logic [6:0] xi);
        case (fs)
            0:       return (xi[0] & xi[1]) | (xi[0] & xi[2]) | (xi[1] & xi[2]);
            1:       return c_tt5[xi];
            2:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb f_in0 = fval(fsel, xv[0]);
    always_ff @(posedge clk) dly <= {dly[1:0], fval(fsel, xv[1])};
    assign f_in3 = dly[2];

    tt_scanner #(.LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .exp_tt(exp_a[0]), .x(xv[0]),
        .f_in(f_in0), .busy(busy[0]), .tt_valid(valid[0]), .tt_ready(ready[0]),
        .tt_data(data[0]), .match(match[0]), .ones(ones[0])
    );

    tt_scanner #(.LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start[1]), .exp_tt(exp_a[1]), .x(xv[1]),
        .f_in(f_in3), .busy(busy[1]), .tt_valid(valid[1]), .tt_ready(ready[1]),
        .tt_data(data[1]), .match(match[1]), .ones(ones[1])
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk({tag, "_x"},     128'(xv[d]),    0);
        chk({tag, "_busy"},  128'(busy[d]),  0);
        chk({tag, "_valid"}, 128'(valid[d]), 0);
        chk({tag, "_data"},  data[d],        0);
        chk({tag, "_match"}, 128'(match[d]), 0);
        chk({tag, "_ones"},  128'(ones[d]),  0);
    endtask

    task automatic chk_result(input int d, input exp_t s, input string tag);
        chk({tag, "_valid"}, 128'(valid[d]), 1);
        chk({tag, "_data"},  data[d],        s.tt);
        chk({tag, "_match"}, 128'(match[d]), 128'(s.m));
        chk({tag, "_ones"},  128'(ones[d]),  128'(s.n));
    endtask

    task automatic scan(input int d, input int lat, input int fs, input tt_t e,
                        input int hold, input string tag);
        exp_t s;
        tt_t  t;
        int   c;
        for (int i = 0; i < 128; i++) t[i] = fval(fs, 7'(i));
        s.tt = t;
        s.m  = (t == e);
        s.n  = 8'($countones(t));
        sb.push_back(s);

        @(negedge clk);
        fsel     = fs;
        exp_a[d] = e;
        start[d] = 1'b1;
        ready[d] = (hold == 0);
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        exp_a[d] = ~e;
        chk({tag, "_x_first"}, 128'(xv[d]), 0);
        chk({tag, "_busy_on"}, 128'(busy[d]), 1);

        c = 1;
        while (!valid[d] && c < 400) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk({tag, "_latency"}, 128'(c), 128'(129 + lat));
        chk({tag, "_busy_off"}, 128'(busy[d]), 0);

        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            s = sb.pop_front();
        end

        if (hold > 0) begin
            start[d] = 1'b1;
            for (int h = 0; h < hold; h++) begin
                chk_result(d, s, {tag, "_hold"});
                @(posedge clk);
                #1;
            end
            ready[d] = 1'b1;
            chk_result(d, s, {tag, "_hs"});
            @(posedge clk);
            #1;
            start[d] = 1'b0;
            chk({tag, "_valid_drop"}, 128'(valid[d]), 0);
            @(posedge clk);
            #1;
            chk({tag, "_idle_busy"}, 128'(busy[d]), 0);
            chk({tag, "_idle_x"}, 128'(xv[d]), 127);
        end else begin
            chk_result(d, s, tag);
            @(posedge clk);
            #1;
            chk({tag, "_valid_drop"}, 128'(valid[d]), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst      = 1'b1;
        start    = 2'b00;
        ready    = 2'b00;
        exp_a[0] = '0;
        exp_a[1] = '0;
        fsel     = 3;
        repeat (3) @(negedge clk);
        chk_zero(0, "reset0");
        chk_zero(1, "reset3");
        rst = 1'b0;

        scan(0, 0, 0, c_maj3, 0, "maj3");
        scan(1, 3, 1, c_tt5, 0, "maj5");
        scan(0, 0, 2, '0, 0, "const1");
        scan(1, 3, 3, '0, 0, "const0");
        scan(0, 0, 0, c_maj3, 10, "stall");

        // Abort a constant-1 scan part way, then confirm a clean rescan.
        @(negedge clk);
        fsel     = 2;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        c = 0;
        while (xv[0] != 7'd60 && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("abort_x60", 128'(xv[0]), 60);
        rst = 1'b1;
        #1;
        chk_zero(0, "rst_mid");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        scan(0, 0, 0, c_maj3, 0, "rescan");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
